// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and helpers for the multiplexing arbiters.
// Mode encodings are plain ints so they can be compared against integer parameters.
package rr_mux_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A channel index is at least one bit wide, even for a single channel.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arb_grant.sv
// Purely combinational grant selection for the mux arbiter.
// Fixed mode grants the lowest requester; round robin searches upward from the pointer with wrap.
module rr_grant
  import rr_mux_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = chan_idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_valid,
  input  logic [IW-1:0]       i_ptr,
  input  logic                i_mode,
  output logic [CHANNELS-1:0] o_grant,
  output logic [IW-1:0]       o_idx,
  output logic                o_any
);

  int w_base;
  int w_c;

  // Scan from the far end down so the last hit is the closest one to the base.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_base  = i_mode ? int'(i_ptr) : 0;
    w_c     = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_c = (w_base + k) % CHANNELS;
      if (i_valid[w_c]) begin
        o_idx = IW'(w_c);
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-to-1 arbitrated mux with a single registered output stage.
// Holds the output word and round-robin pointer; grant selection lives in rr_grant.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = ARB_RR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               in_valid,
  input  logic [CHANNELS*WIDTH-1:0]         in_data,
  output logic [CHANNELS-1:0]               in_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  output logic [chan_idx_w(CHANNELS)-1:0]   out_chan,
  input  logic                              out_ready
);

  localparam int IW = chan_idx_w(CHANNELS);

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [IW-1:0]       r_chan;
  logic [IW-1:0]       r_ptr;

  logic [CHANNELS-1:0] w_grant;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_can_load;
  logic                w_in_xfer;
  logic [WIDTH-1:0]    w_sel_data;

  rr_grant #(
    .CHANNELS (CHANNELS),
    .IW       (IW)
  ) u_grant (
    .i_valid (in_valid),
    .i_ptr   (r_ptr),
    .i_mode  (MODE == ARB_RR),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The register can take a new word when empty or when its word leaves this cycle.
  assign w_can_load = !r_valid || out_ready;
  assign w_in_xfer  = w_any && w_can_load && !rst;
  assign in_ready   = w_in_xfer ? w_grant : '0;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(w_idx) == i) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_chan  <= w_idx;
        if (MODE == ARB_RR) begin
          r_ptr <= (w_idx == IW'(CHANNELS - 1)) ? '0 : w_idx + 1'b1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench: directed round-robin/backpressure/reset sequences, a fixed-priority
// vector table, and a randomized run against a queue-based reference model.
module tb_rr_mux_arb;
  import rr_mux_arb_pkg::*;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  always #5 clk = ~clk;

  logic [C-1:0]   in_valid, in_ready;
  logic [C*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;

  logic [C-1:0]   fp_in_valid, fp_in_ready;
  logic [C*W-1:0] fp_in_data;
  logic           fp_out_valid, fp_out_ready;
  logic [W-1:0]   fp_out_data;
  logic [1:0]     fp_out_chan;

  rr_mux_arb #(.WIDTH(W), .CHANNELS(C), .MODE(ARB_RR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready));

  rr_mux_arb #(.WIDTH(W), .CHANNELS(C), .MODE(ARB_FIXED)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(fp_in_valid), .in_data(fp_in_data), .in_ready(fp_in_ready),
    .out_valid(fp_out_valid), .out_data(fp_out_data), .out_chan(fp_out_chan),
    .out_ready(fp_out_ready));

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_5c   = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (out_data == 8'h5C) n_5c++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [C-1:0] vld;
    logic [C-1:0] exp_rdy;
    logic         exp_ov;
    int           exp_ch;
  } fp_vec_t;

  typedef struct {
    logic [W-1:0] data;
    int           chan;
  } word_t;

  fp_vec_t fp_tbl[8];
  word_t   q[$];

  initial begin
    int snap;
    int ptr;
    int g;
    logic [C-1:0] exp_rdy;
    logic full;

    fp_tbl[0] = '{4'b1010, 4'b0010, 1'b1, 1};
    fp_tbl[1] = '{4'b1010, 4'b0010, 1'b1, 1};
    fp_tbl[2] = '{4'b1010, 4'b0010, 1'b1, 1};
    fp_tbl[3] = '{4'b1000, 4'b1000, 1'b1, 3};
    fp_tbl[4] = '{4'b0000, 4'b0000, 1'b0, 0};
    fp_tbl[5] = '{4'b0111, 4'b0001, 1'b1, 0};
    fp_tbl[6] = '{4'b1100, 4'b0100, 1'b1, 2};
    fp_tbl[7] = '{4'b1111, 4'b0001, 1'b1, 0};

    rst          = 1'b1;
    in_valid     = 4'hF;
    in_data      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready    = 1'b1;
    fp_in_valid  = 4'h0;
    fp_in_data   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    fp_out_ready = 1'b1;

    // Reset with every channel requesting
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_chan", 32'(out_chan), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_fp_out_valid", 32'(fp_out_valid), 0);

    // Round robin with all channels valid
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_out_valid", 32'(out_valid), 1);
      chk("rr_out_chan", 32'(out_chan), 32'(k % 4));
      chk("rr_out_data", 32'(out_data), 32'(8'hA0 + k % 4));
      chk("rr_next_ready", 32'(in_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Backpressure on a held 0x5C word
    in_data[23:16] = 8'h5C;
    in_valid = 4'b0100;
    tick();
    chk("bp_load_data", 32'(out_data), 32'h5C);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 32'h5C);
      chk("bp_hold_chan", 32'(out_chan), 2);
    end
    chk("bp_no_early_drain", 32'(n_5c), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_ptr_kept", 32'(in_ready), 32'b1000);
    tick();
    chk("bp_next_chan", 32'(out_chan), 3);
    chk("bp_next_data", 32'(out_data), 32'hA3);
    chk("bp_drained_once", 32'(n_5c), 1);
    in_valid = 4'b0000;
    #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    tick();
    chk("idle_out_valid", 32'(out_valid), 0);

    // Sparse round robin, wrap search, and a withdrawn request
    in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid = 4'b0100;
    tick();
    chk("sp_chan2", 32'(out_chan), 2);
    out_ready = 1'b0;
    #1;
    chk("wd_blocked", 32'(in_ready), 0);
    tick();
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk("wd_drained", 32'(out_valid), 0);
    in_valid = 4'b0100;
    #1;
    chk("sp_wrap_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("sp_wrap_chan", 32'(out_chan), 2);
    in_valid = 4'b1001;
    #1;
    chk("sp_ptr3_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("sp_ptr3_chan", 32'(out_chan), 3);
    in_valid = 4'b1111;
    #1;
    chk("sp_ptr_wrap0", 32'(in_ready), 32'b0001);

    // Reset while a word is held under backpressure
    tick();
    chk("mr_loaded_chan", 32'(out_chan), 0);
    out_ready = 1'b0;
    tick();
    chk("mr_held", 32'(out_valid), 1);
    snap = n_out;
    rst = 1'b1;
    #1;
    chk("mr_in_ready_rst", 32'(in_ready), 0);
    tick();
    chk("mr_cleared", 32'(out_valid), 0);
    rst       = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk("mr_still_empty", 32'(out_valid), 0);
    chk("mr_no_xfer", 32'(n_out), 32'(snap));
    in_valid = 4'hF;
    #1;
    chk("mr_first_grant", 32'(in_ready), 32'h1);

    // Fixed priority vector table
    in_valid = 4'h0;
    for (int i = 0; i < 8; i++) begin
      fp_in_valid = fp_tbl[i].vld;
      #1;
      chk("fp_in_ready", 32'(fp_in_ready), 32'(fp_tbl[i].exp_rdy));
      tick();
      chk("fp_out_valid", 32'(fp_out_valid), 32'(fp_tbl[i].exp_ov));
      if (fp_tbl[i].exp_ov) begin
        chk("fp_out_chan", 32'(fp_out_chan), 32'(fp_tbl[i].exp_ch));
        chk("fp_out_data", 32'(fp_out_data), 32'(8'hB0 + fp_tbl[i].exp_ch));
      end
    end
    fp_in_valid = 4'h0;

    // Randomized traffic against a queue-based model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int j = 0; j < C; j++) begin
        if (g < 0 && in_valid[(ptr + j) % C]) g = (ptr + j) % C;
      end
      full    = (q.size() != 0);
      exp_rdy = (g >= 0 && (!full || out_ready)) ? 4'(1 << g) : 4'b0;
      chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rand_out_valid", 32'(out_valid), 32'(full));
      if (full) begin
        chk("rand_out_data", 32'(out_data), 32'(q[0].data));
        chk("rand_out_chan", 32'(out_chan), 32'(q[0].chan));
      end
      if (full && out_ready) void'(q.pop_front());
      if (exp_rdy != 0) begin
        q.push_back('{in_data[g*W +: W], g});
        ptr = (g + 1) % C;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits.
REQ-002 Parameter CHANNELS, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter MODE, default 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round robin.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  CHANNELS  per-channel request; bit i set means in_data slice i is valid.
REQ-007 in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  CHANNELS  per-channel accept; at most one bit is set in any cycle.
REQ-009 out_valid  output  1  output register holds a valid word.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_chan  output  max(1,$clog2(CHANNELS))  index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; a transfer on the output SHALL occur in a cycle where out_valid and out_ready are both 1.
REQ-014 The grant SHALL be combinational from in_valid and the priority pointer: MODE 0 grants the lowest set index; MODE 1 grants the first set index at or after the pointer, searching upward with wrap.
REQ-015 in_ready[g] SHALL be 1 only for the granted channel g, and only when (out_valid == 0) or (out_ready == 1); all other bits SHALL be 0.
REQ-016 in_ready SHALL be all zeros when in_valid is all zeros.
REQ-017 On an input transfer, out_data and out_chan SHALL load the granted word and index on the next edge, and out_valid SHALL be 1. Latency is one cycle from input transfer to out_valid.
REQ-018 An output transfer with no simultaneous input transfer SHALL clear out_valid on the next edge.
REQ-019 A simultaneous output and input transfer SHALL reload the register with no bubble, sustaining one word per cycle.
REQ-020 While out_valid == 1 and out_ready == 0, out_data, out_chan, and out_valid SHALL hold stable, and in_ready SHALL be all zeros.
REQ-021 In MODE 1, the pointer SHALL advance to (g+1) mod CHANNELS after each input transfer, wrapping from CHANNELS-1 to 0. Otherwise the pointer SHALL hold.
REQ-022 In MODE 0, the pointer SHALL be unused and held at 0.
REQ-023 In MODE 1 with all channels continuously requesting, grants SHALL cycle 0, 1, ..., CHANNELS-1, 0, ... with no channel granted twice before every other requester has been granted once.
REQ-024 Withdrawal of in_valid[i] before it is granted SHALL be tolerated: the word is never transferred and the pointer is unaffected.

Reset
REQ-025 While rst is high at a rising edge, the next state SHALL be: out_valid = 0, out_data = 0, out_chan = 0, pointer = 0.
REQ-026 While rst is high, in_ready SHALL be all zeros.
REQ-027 Reset asserted mid-stream SHALL discard any word held in the output register without an output transfer.
REQ-028 The first grant after reset release SHALL start search at channel 0.

Structure
REQ-029 A shared package SHALL hold the mode constants ARB_FIXED = 0 and ARB_RR = 1 and a function for the channel-index width; the codebase's muxes and arbiters SHALL use this package.
REQ-030 Grant logic SHALL be one sub-module, rr_grant, which is purely combinational. It takes in_valid, the pointer, and the mode, and produces a one-hot grant, a grant index, and an any-grant flag.
REQ-031 The datapath register and the pointer register SHALL reside in rr_mux_arb. The expected size is 120-400 lines of RTL in total.

Verification
REQ-032 Reset: assert rst for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0. The first post-reset grant is channel 0.
REQ-033 Round robin (WIDTH 8, CHANNELS 4, MODE 1), all channels valid with data 0xA0+i, out_ready = 1 -> out_chan sequence 0,1,2,3,0,1. out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1. out_valid stays high every cycle after the first.
REQ-034 Backpressure: hold out_ready = 0 for 5 cycles with out_valid = 1 and out_data = 0x5C -> out_data holds 0x5C, in_ready = 0, pointer unchanged. On release, exactly one word drains and the next grant follows.
REQ-035 Fixed priority (MODE 0), in_valid = 4'b1010 -> channel 1 is granted repeatedly. Channel 3 is granted only once in_valid[1] drops.
REQ-036 Sparse round robin: pointer = 3, in_valid = 4'b0100 -> channel 2 is granted (wrap search) and the pointer becomes 3. Then in_valid = 4'b1001 -> channel 3 is granted and the pointer wraps to 0.
REQ-037 Reset mid-stream: assert rst while out_valid = 1 and out_ready = 0 -> out_valid = 0 on the next edge, and the held word is never observed as an output transfer.
